// File: rtl/align16_pre_if.sv
// Bus bundle for align16_pre: operand-pair input handshake and aligned-operand
// output handshake. master = producer/consumer side, slave = the align stage.
interface align16_pre_if;
  logic [15:0] in_a_half;
  logic [15:0] in_b_half;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  out_exp_half;
  logic [10:0] out_mant_a_half;
  logic [10:0] out_mant_b_half;
  logic        out_sticky;
  logic        out_sign;
  logic        out_eff_sub;
  logic [1:0]  out_special;
  logic        out_valid;
  logic        out_ready;

  modport master (
    output in_a_half, in_b_half, in_valid, out_ready,
    input  in_ready, out_exp_half, out_mant_a_half, out_mant_b_half,
           out_sticky, out_sign, out_eff_sub, out_special, out_valid
  );

  modport slave (
    input  in_a_half, in_b_half, in_valid, out_ready,
    output in_ready, out_exp_half, out_mant_a_half, out_mant_b_half,
           out_sticky, out_sign, out_eff_sub, out_special, out_valid
  );
endinterface

// File: rtl/align16_pre.sv
// align16_pre: two-stage FP16 operand alignment ahead of the magnitude adder.
// Stage 1 unpacks and orders the operands by magnitude; stage 2 right-shifts
// the smaller significand and collects sticky. Optional macro
// ALIGN16_SPECIAL_DETECT_EN adds infinity/NaN classification on out_special;
// without it out_special is constant 00 and exp==31 is treated as normal.
module align16_pre (
  input  logic         clk,
  input  logic         rst_n,
  align16_pre_if.slave bus
);

  // Unpacked operands: denormals/zero get hidden bit 0 and exponent 1
  logic [4:0]  exp_a, exp_b, exp_l, exp_s;
  logic [10:0] mant_a, mant_b, mant_l, mant_s;
  logic        sign_a, sign_b, sign_l, eff_sub, swap, sign_next;

  assign sign_a  = bus.in_a_half[15];
  assign sign_b  = bus.in_b_half[15];
  assign exp_a   = (bus.in_a_half[14:10] == 5'd0) ? 5'd1 : bus.in_a_half[14:10];
  assign exp_b   = (bus.in_b_half[14:10] == 5'd0) ? 5'd1 : bus.in_b_half[14:10];
  assign mant_a  = {|bus.in_a_half[14:10], bus.in_a_half[9:0]};
  assign mant_b  = {|bus.in_b_half[14:10], bus.in_b_half[9:0]};

  // Strictly-greater compare keeps A as the larger operand on a tie
  assign swap    = {exp_b, mant_b} > {exp_a, mant_a};
  assign exp_l   = swap ? exp_b  : exp_a;
  assign exp_s   = swap ? exp_a  : exp_b;
  assign mant_l  = swap ? mant_b : mant_a;
  assign mant_s  = swap ? mant_a : mant_b;
  assign sign_l  = swap ? sign_b : sign_a;
  assign eff_sub = sign_a ^ sign_b;

`ifdef ALIGN16_SPECIAL_DETECT_EN
  logic       inf_a, inf_b, nan_a, nan_b;
  logic [1:0] special_next;

  assign inf_a = (bus.in_a_half[14:10] == 5'h1f) && (bus.in_a_half[9:0] == 10'd0);
  assign inf_b = (bus.in_b_half[14:10] == 5'h1f) && (bus.in_b_half[9:0] == 10'd0);
  assign nan_a = (bus.in_a_half[14:10] == 5'h1f) && (bus.in_a_half[9:0] != 10'd0);
  assign nan_b = (bus.in_b_half[14:10] == 5'h1f) && (bus.in_b_half[9:0] != 10'd0);

  assign special_next = (nan_a || nan_b || (inf_a && inf_b && eff_sub)) ? 2'b11 :
                        (inf_a || inf_b)                                ? 2'b10 : 2'b00;
  // An infinite result carries the sign of the infinite operand
  assign sign_next = (special_next == 2'b10) ? (inf_a ? sign_a : sign_b) : sign_l;
`else
  assign sign_next = sign_l;
`endif

  // Pipeline control: stage 2 drains when empty or consumer ready
  logic s1_valid, s2_valid, s1_advance, s2_advance;

  assign s2_advance   = !s2_valid || bus.out_ready;
  assign s1_advance   = s1_valid && s2_advance;
  assign bus.in_ready = !s1_valid || s1_advance;

  logic [4:0]  s1_exp, s1_d;
  logic [10:0] s1_mant_l, s1_mant_s;
  logic        s1_sign, s1_eff_sub;

  // Stage 1: capture the ordered operands and exponent difference on accept
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid   <= 1'b0;
      s1_exp     <= 5'd0;
      s1_d       <= 5'd0;
      s1_mant_l  <= 11'd0;
      s1_mant_s  <= 11'd0;
      s1_sign    <= 1'b0;
      s1_eff_sub <= 1'b0;
    end else if (bus.in_ready) begin
      s1_valid <= bus.in_valid;
      if (bus.in_valid) begin
        s1_exp     <= exp_l;
        s1_d       <= exp_l - exp_s;
        s1_mant_l  <= mant_l;
        s1_mant_s  <= mant_s;
        s1_sign    <= sign_next;
        s1_eff_sub <= eff_sub;
      end
    end
  end

  // Alignment: a shift of 11 or more empties the significand and the mask
  // wraps to all ones, so every bit lands in sticky without a special case
  logic [10:0] sticky_mask, mant_b_next;
  logic        sticky_next;

  assign sticky_mask = (11'd1 << s1_d) - 11'd1;
  assign mant_b_next = s1_mant_s >> s1_d;
  assign sticky_next = |(s1_mant_s & sticky_mask);

  // Stage 2: register the aligned bundle; holds while the consumer stalls
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid            <= 1'b0;
      bus.out_exp_half    <= 5'd0;
      bus.out_mant_a_half <= 11'd0;
      bus.out_mant_b_half <= 11'd0;
      bus.out_sticky      <= 1'b0;
      bus.out_sign        <= 1'b0;
      bus.out_eff_sub     <= 1'b0;
    end else if (s2_advance) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        bus.out_exp_half    <= s1_exp;
        bus.out_mant_a_half <= s1_mant_l;
        bus.out_mant_b_half <= mant_b_next;
        bus.out_sticky      <= sticky_next;
        bus.out_sign        <= s1_sign;
        bus.out_eff_sub     <= s1_eff_sub;
      end
    end
  end

  assign bus.out_valid = s2_valid;

`ifdef ALIGN16_SPECIAL_DETECT_EN
  logic [1:0] s1_special, s2_special;

  // Special class travels alongside the data through both stages
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_special <= 2'b00;
      s2_special <= 2'b00;
    end else begin
      if (bus.in_ready && bus.in_valid) s1_special <= special_next;
      if (s2_advance && s1_valid)       s2_special <= s1_special;
    end
  end

  assign bus.out_special = s2_special;
`else
  assign bus.out_special = 2'b00;
`endif

endmodule

// File: tb/tb_align16_pre.sv
// Directed testbench for align16_pre: single-pair vectors with hand-computed
// results, a stalled burst, and a mid-flight reset.
module tb_align16_pre;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  align16_pre_if bus ();

  align16_pre dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

`ifdef ALIGN16_SPECIAL_DETECT_EN
  localparam logic [1:0] SP_NAN = 2'b11;
  localparam logic [1:0] SP_INF = 2'b10;
`else
  localparam logic [1:0] SP_NAN = 2'b00;
  localparam logic [1:0] SP_INF = 2'b00;
`endif

  // {exp, mant_a, mant_b, sticky, sign, eff_sub}
  logic [29:0] out_bundle;
  assign out_bundle = {bus.out_exp_half, bus.out_mant_a_half, bus.out_mant_b_half,
                       bus.out_sticky, bus.out_sign, bus.out_eff_sub};

  function automatic logic [29:0] bnd(input logic [4:0] e, input logic [10:0] ma,
                                      input logic [10:0] mb, input logic st,
                                      input logic sg, input logic es);
    return {e, ma, mb, st, sg, es};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv)
      else begin
        bad++;
        $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
  endtask

  // One pair through an idle pipe: absent one edge after accept, present after two
  task automatic run_vec(input string tag, input logic [15:0] a, input logic [15:0] b,
                         input logic [29:0] eb, input logic [1:0] esp);
    @(negedge clk);
    bus.in_a_half = a;
    bus.in_b_half = b;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    #1;
    chk({tag, ".in_ready"}, 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk({tag, ".valid_early"}, 32'(bus.out_valid), 32'd0);
    @(negedge clk);
    chk({tag, ".valid"}, 32'(bus.out_valid), 32'd1);
    chk({tag, ".bundle"}, 32'(out_bundle), 32'(eb));
    chk({tag, ".special"}, 32'(bus.out_special), 32'(esp));
    $display("vec %s a=%h b=%h out=%h special=%b", tag, a, b, out_bundle, bus.out_special);
  endtask

  logic [15:0] a_tab [5];
  logic [15:0] b_tab [5];
  logic [29:0] e_tab [5];
  int          sent, recv;
  logic        hs_in, hs_out, prev_stalled;
  logic [29:0] snap;

  initial begin
    bus.in_a_half = 16'h0;
    bus.in_b_half = 16'h0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst.valid", 32'(bus.out_valid), 32'd0);
    chk("rst.bundle", 32'(out_bundle), 32'd0);
    chk("rst.special", 32'(bus.out_special), 32'd0);
    chk("rst.in_ready", 32'(bus.in_ready), 32'd1);
    rst_n = 1'b1;

    // Directed single vectors
    run_vec("add",     16'h3C00, 16'h3800, bnd(5'd15, 11'h400, 11'h200, 1'b0, 1'b0, 1'b0), 2'b00);
    run_vec("swap",    16'h3800, 16'hBC00, bnd(5'd15, 11'h400, 11'h200, 1'b0, 1'b1, 1'b1), 2'b00);
    run_vec("d10",     16'h3C00, 16'h1401, bnd(5'd15, 11'h400, 11'h001, 1'b1, 1'b0, 1'b0), 2'b00);
    run_vec("d14",     16'h3C00, 16'h0001, bnd(5'd15, 11'h400, 11'h000, 1'b1, 1'b0, 1'b0), 2'b00);
    run_vec("equal",   16'h3C00, 16'h3C00, bnd(5'd15, 11'h400, 11'h400, 1'b0, 1'b0, 1'b0), 2'b00);
    run_vec("d2",      16'h4500, 16'h3E00, bnd(5'd17, 11'h500, 11'h180, 1'b0, 1'b0, 1'b0), 2'b00);
    run_vec("d1stk",   16'h4000, 16'h3C01, bnd(5'd16, 11'h400, 11'h200, 1'b1, 1'b0, 1'b0), 2'b00);

    // Burst of 5 with consumer stalled for cycles 2..5
    a_tab[0] = 16'h3C00; b_tab[0] = 16'h3800; e_tab[0] = bnd(5'd15, 11'h400, 11'h200, 1'b0, 1'b0, 1'b0);
    a_tab[1] = 16'h3800; b_tab[1] = 16'hBC00; e_tab[1] = bnd(5'd15, 11'h400, 11'h200, 1'b0, 1'b1, 1'b1);
    a_tab[2] = 16'h3C00; b_tab[2] = 16'h1401; e_tab[2] = bnd(5'd15, 11'h400, 11'h001, 1'b1, 1'b0, 1'b0);
    a_tab[3] = 16'h4500; b_tab[3] = 16'h3E00; e_tab[3] = bnd(5'd17, 11'h500, 11'h180, 1'b0, 1'b0, 1'b0);
    a_tab[4] = 16'h4000; b_tab[4] = 16'h3C01; e_tab[4] = bnd(5'd16, 11'h400, 11'h200, 1'b1, 1'b0, 1'b0);
    sent = 0;
    recv = 0;
    prev_stalled = 1'b0;
    snap = '0;
    for (int c = 0; c < 30 && recv < 5; c++) begin
      @(negedge clk);
      bus.out_ready = !(c >= 2 && c < 6);
      bus.in_valid  = (sent < 5);
      if (sent < 5) begin
        bus.in_a_half = a_tab[sent];
        bus.in_b_half = b_tab[sent];
      end
      #1;
      hs_in  = bus.in_valid && bus.in_ready;
      hs_out = bus.out_valid && bus.out_ready;
      if (prev_stalled) chk($sformatf("burst.stable%0d", c), 32'(out_bundle), 32'(snap));
      if (c == 3) begin
        chk("burst.in_ready_low", 32'(bus.in_ready), 32'd0);
        chk("burst.held", 32'(sent - recv), 32'd2);
      end
      if (hs_out) begin
        chk($sformatf("burst.out%0d", recv), 32'(out_bundle), 32'(e_tab[recv]));
        $display("burst out %0d bundle=%h", recv, out_bundle);
        recv++;
      end
      prev_stalled = bus.out_valid && !bus.out_ready;
      snap = out_bundle;
      if (hs_in) sent++;
      @(posedge clk);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk("burst.recv", 32'(recv), 32'd5);
    chk("burst.sent", 32'(sent), 32'd5);
    @(negedge clk);
    chk("burst.no_dup", 32'(bus.out_valid), 32'd0);

    // Two pairs in flight, then reset pulse between edges
    @(negedge clk);
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_a_half = 16'h3C00;
    bus.in_b_half = 16'h3800;
    @(negedge clk);
    bus.in_a_half = 16'h4500;
    bus.in_b_half = 16'h3E00;
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk("flight.valid", 32'(bus.out_valid), 32'd1);
    chk("flight.in_ready", 32'(bus.in_ready), 32'd0);
    rst_n = 1'b0;
    #1;
    chk("midrst.valid", 32'(bus.out_valid), 32'd0);
    chk("midrst.bundle", 32'(out_bundle), 32'd0);
    chk("midrst.in_ready", 32'(bus.in_ready), 32'd1);
    #1;
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk($sformatf("midrst.stale%0d", c), 32'(bus.out_valid), 32'd0);
    end
    $display("reset pulse done, no stale output");

    // Special operands
    run_vec("infinf",  16'h7C00, 16'hFC00, bnd(5'd31, 11'h400, 11'h400, 1'b0, 1'b0, 1'b1), SP_NAN);
    run_vec("nan",     16'h7E00, 16'h3C00, bnd(5'd31, 11'h600, 11'h000, 1'b1, 1'b0, 1'b0), SP_NAN);
    run_vec("neginf",  16'hFC00, 16'h3C00, bnd(5'd31, 11'h400, 11'h000, 1'b1, 1'b1, 1'b1), SP_INF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
